// File: rtl/spi_master_ram_ctrl.sv
// SPI master that turns parallel commands into SS_n-framed serial transfers for the SPI-slave/RAM subsystem.
// Optional macro SPI_MASTER_SEQ_CHECK_EN adds cmd_err, flagging rd-data issued without a preceding rd-addr.
module spi_master_ram_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int GAP     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       MOSI,
  output logic       SS_n,
  input  logic       MISO
`ifdef SPI_MASTER_SEQ_CHECK_EN
  ,
  output logic       cmd_err
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] GAP_LAST  = 4'(GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL,
    S_SHIFT,
    S_WAIT,
    S_RECV,
    S_GAP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic [3:0]  r_cnt;
  logic [1:0]  r_cmd;
  logic [9:0]  r_sreg;
  logic [6:0]  r_rx;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_data;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    SS_n      = 1'b0;
    MOSI      = 1'b0;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        SS_n      = 1'b1;
        if (cmd_valid) begin
          w_accept = 1'b1;
          w_next   = S_CTRL;
        end
      end
      // the control bit equals cmd_type[1], which is also the top bit of the word
      S_CTRL: begin
        MOSI   = r_sreg[9];
        w_next = S_SHIFT;
      end
      S_SHIFT: begin
        MOSI = r_sreg[9];
        if (r_cnt == 4'd0) w_next = (r_cmd == 2'b11) ? S_WAIT : S_GAP;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next = S_RECV;
      end
      S_RECV: begin
        if (r_cnt == 4'd0) w_next = S_GAP;
      end
      S_GAP: begin
        SS_n = 1'b1;
        if (r_cnt == 4'd0) w_next = S_IDLE;
      end
      default: begin
        SS_n   = 1'b1;
        w_next = S_IDLE;
      end
    endcase
  end

  // one down-counter serves every timed state; it is reloaded on each state change
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= 4'd0;
      r_cmd <= 2'b00;
    end else begin
      if (w_accept) r_cmd <= cmd_type;
      if (w_next != r_state) begin
        case (w_next)
          S_SHIFT: r_cnt <= 4'd9;
          S_WAIT:  r_cnt <= WAIT_LAST;
          S_RECV:  r_cnt <= 4'd7;
          S_GAP:   r_cnt <= GAP_LAST;
          default: r_cnt <= 4'd0;
        endcase
      end else if (r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept)                r_sreg <= {cmd_type, cmd_data};
    else if (r_state == S_SHIFT) r_sreg <= {r_sreg[8:0], 1'b0};
    if (r_state == S_RECV)       r_rx   <= {r_rx[5:0], MISO};
  end

  // the eighth sample goes straight into rsp_data as the frame enters GAP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= 8'h00;
    end else begin
      r_rsp_valid <= (r_state == S_RECV) && (r_cnt == 4'd0);
      if ((r_state == S_RECV) && (r_cnt == 4'd0)) r_rsp_data <= {r_rx, MISO};
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic r_rd_addr_sent;
  logic r_cmd_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_addr_sent <= 1'b0;
      r_cmd_err      <= 1'b0;
    end else begin
      r_cmd_err <= w_accept && (cmd_type == 2'b11) && !r_rd_addr_sent;
      if (w_accept && (cmd_type == 2'b10)) r_rd_addr_sent <= 1'b1;
      if (w_accept && (cmd_type == 2'b11)) r_rd_addr_sent <= 1'b0;
    end
  end

  assign cmd_err = r_cmd_err;
`endif

endmodule
